// File: rtl/add_arbiter.sv
// Four-requester round-robin arbiter that owns a single registered adder.
// One operation at a time: grant in IDLE, add in EXEC, hold the result in RESP until taken.
module add_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_cin,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [1:0]              resp_id,
    output logic [WIDTH-1:0]        resp_sum,
    output logic                    resp_cout,
    output logic                    busy,
    output logic [15:0]             op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [1:0]       id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic [15:0]      count_q, count_d;

    logic             grant_found;
    logic [1:0]       grant_idx;
    logic             accept;

    // Search from rr_ptr upward; the 2-bit index wraps modulo 4 on its own.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = rr_ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[rr_ptr_q + 2'(k)]) begin
                grant_found = 1'b1;
                grant_idx   = rr_ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == IDLE) && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d      = req_a[int'(grant_idx)*WIDTH +: WIDTH];
                    b_d      = req_b[int'(grant_idx)*WIDTH +: WIDTH];
                    cin_d    = req_cin[grant_idx];
                    id_d     = grant_idx;
                    rr_ptr_d = grant_idx + 2'd1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                {cout_d, sum_d} = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(cin_q);
                state_d         = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    count_d = count_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= 2'd0;
            id_q     <= 2'd0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            count_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            count_q  <= count_d;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_id    = id_q;
    assign resp_sum   = sum_q;
    assign resp_cout  = cout_q;
    assign busy       = (state_q != IDLE);
    assign op_count   = count_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: reset, single op, carry, fairness, backpressure,
// withdrawal, reset mid-operation and op_count wrap.
module tb_add_arbiter;

    localparam int W = 16;

    logic          clk;
    logic          rst_n;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [4*W-1:0] req_a;
    logic [4*W-1:0] req_b;
    logic [3:0]    req_cin;
    logic          resp_valid;
    logic          resp_ready;
    logic [1:0]    resp_id;
    logic [W-1:0]  resp_sum;
    logic          resp_cout;
    logic          busy;
    logic [15:0]   op_count;

    int checks   = 0;
    int failures = 0;

    add_arbiter #(.NREQ(4), .WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .busy       (busy),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = c;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req_valid = 4'h0; resp_ready = 1'b1;
        req_a = '0; req_b = '0; req_cin = '0;
        #2 rst_n = 1'b0;
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (op_count !== 16'h0000) begin failures++; $display("FAIL reset_op_count got=%h exp=0000", op_count); end
        checks++; if ({resp_id, resp_cout, resp_sum} !== 19'h0) begin failures++; $display("FAIL reset_resp_data got=%h exp=0", {resp_id, resp_cout, resp_sum}); end
        @(negedge clk);
        rst_n = 1'b1; req_valid = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_single();
        set_op(0, 16'h1234, 16'h0001, 1'b0);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
        @(negedge clk); req_valid = 4'b0000; #1;
        checks++; if ({busy, resp_valid, req_ready} !== 6'b100000) begin failures++; $display("FAIL single_exec got busy/valid/ready=%b exp=100000", {busy, resp_valid, req_ready}); end
        @(negedge clk); #1;
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL single_resp_valid got=%b exp=1", resp_valid); end
        checks++; if ({resp_id, resp_cout, resp_sum} !== {2'd0, 1'b0, 16'h1235}) begin failures++; $display("FAIL single_result got id=%0d cout=%b sum=%h exp id=0 cout=0 sum=1235", resp_id, resp_cout, resp_sum); end
        @(negedge clk); #1;
        checks++; if ({resp_valid, busy} !== 2'b00) begin failures++; $display("FAIL single_done got valid/busy=%b exp=00", {resp_valid, busy}); end
        checks++; if (op_count !== 16'd1) begin failures++; $display("FAIL single_op_count got=%h exp=0001", op_count); end
    endtask

    task automatic test_carry();
        set_op(2, 16'hFFFF, 16'h0000, 1'b1);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL carry_grant got=%b exp=0100", req_ready); end
        @(negedge clk); req_valid = 4'b0000;
        @(negedge clk); #1;
        checks++; if ({resp_valid, resp_id, resp_cout, resp_sum} !== {1'b1, 2'd2, 1'b1, 16'h0000}) begin failures++; $display("FAIL carry_result got valid=%b id=%0d cout=%b sum=%h exp valid=1 id=2 cout=1 sum=0000", resp_valid, resp_id, resp_cout, resp_sum); end
        @(negedge clk); #1;
        checks++; if (op_count !== 16'd2) begin failures++; $display("FAIL carry_op_count got=%h exp=0002", op_count); end
    endtask

    task automatic test_fairness();
        int          exp_id  [5] = '{0, 1, 2, 3, 0};
        logic [W-1:0] exp_sum[4] = '{16'h1211, 16'h2324, 16'h3435, 16'h4548};
        rst_n = 1'b0; #1 rst_n = 1'b1;
        set_op(0, 16'h1111, 16'h0100, 1'b0);
        set_op(1, 16'h2222, 16'h0101, 1'b1);
        set_op(2, 16'h3333, 16'h0102, 1'b0);
        set_op(3, 16'h4444, 16'h0103, 1'b1);
        req_valid = 4'hF;
        #1;
        for (int g = 0; g < 5; g++) begin
            checks++; if (req_ready !== (4'b0001 << exp_id[g])) begin failures++; $display("FAIL fair_grant%0d got=%b exp_id=%0d", g, req_ready, exp_id[g]); end
            @(negedge clk); #1;
            checks++; if ({req_ready, resp_valid} !== 5'b00000) begin failures++; $display("FAIL fair_exec%0d got ready/valid=%b exp=00000", g, {req_ready, resp_valid}); end
            @(negedge clk); #1;
            checks++; if ({resp_valid, resp_id, resp_cout, resp_sum} !== {1'b1, 2'(exp_id[g]), 1'b0, exp_sum[exp_id[g]]}) begin failures++; $display("FAIL fair_resp%0d got valid=%b id=%0d sum=%h exp id=%0d sum=%h", g, resp_valid, resp_id, resp_sum, exp_id[g], exp_sum[exp_id[g]]); end
            @(negedge clk); #1;
            checks++; if (op_count !== 16'(g + 1)) begin failures++; $display("FAIL fair_count%0d got=%h exp=%0d", g, op_count, g + 1); end
        end
        req_valid = 4'h0;
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        set_op(1, 16'h00FF, 16'h0001, 1'b0);
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_grant got=%b exp=0010", req_ready); end
        @(negedge clk); req_valid = 4'hF;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if ({resp_valid, resp_id, resp_cout, resp_sum} !== {1'b1, 2'd1, 1'b0, 16'h0100}) begin failures++; $display("FAIL bp_hold%0d got valid=%b id=%0d sum=%h exp valid=1 id=1 sum=0100", c, resp_valid, resp_id, resp_sum); end
            checks++; if ({req_ready, op_count} !== {4'b0000, 16'd5}) begin failures++; $display("FAIL bp_side%0d got ready=%b count=%h exp ready=0000 count=0005", c, req_ready, op_count); end
            @(negedge clk);
        end
        resp_ready = 1'b1; req_valid = 4'h0;
        @(negedge clk); #1;
        checks++; if ({resp_valid, op_count} !== {1'b0, 16'd6}) begin failures++; $display("FAIL bp_release got valid=%b count=%h exp valid=0 count=0006", resp_valid, op_count); end
    endtask

    task automatic test_withdraw();
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL wd_grant got=%b exp=0100", req_ready); end
        req_valid = 4'h0;
        @(negedge clk); #1;
        checks++; if ({busy, op_count} !== {1'b0, 16'd6}) begin failures++; $display("FAIL wd_noeffect got busy=%b count=%h exp busy=0 count=0006", busy, op_count); end
        repeat (2) @(negedge clk);
        req_valid = 4'b0101;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL wd_ptr_kept got=%b exp=0100", req_ready); end
        req_valid = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        set_op(3, 16'h0F0F, 16'hF0F0, 1'b1);
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL rmo_grant got=%b exp=1000", req_ready); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmo_exec got busy=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, resp_valid, req_ready} !== 6'b000000) begin failures++; $display("FAIL rmo_ctrl got busy/valid/ready=%b exp=000000", {busy, resp_valid, req_ready}); end
        checks++; if ({resp_id, resp_cout, resp_sum, op_count} !== 35'h0) begin failures++; $display("FAIL rmo_data got id=%0d cout=%b sum=%h count=%h exp all 0", resp_id, resp_cout, resp_sum, op_count); end
        @(negedge clk);
        rst_n = 1'b1; req_valid = 4'h0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if ({resp_valid, busy, op_count} !== 18'h0) begin failures++; $display("FAIL rmo_quiet%0d got valid=%b busy=%b count=%h exp 0", c, resp_valid, busy, op_count); end
            @(negedge clk);
        end
        req_valid = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rmo_lowest got=%b exp=0010", req_ready); end
        @(negedge clk); req_valid = 4'h0;
        @(negedge clk); #1;
        checks++; if ({resp_valid, resp_id, resp_sum} !== {1'b1, 2'd1, 16'h0100}) begin failures++; $display("FAIL rmo_resp got valid=%b id=%0d sum=%h exp valid=1 id=1 sum=0100", resp_valid, resp_id, resp_sum); end
        @(negedge clk); #1;
        checks++; if (op_count !== 16'd1) begin failures++; $display("FAIL rmo_count got=%h exp=0001", op_count); end
    endtask

    task automatic test_wrap();
        dut.count_q = 16'hFFFF;
        set_op(0, 16'h0007, 16'h0008, 1'b0);
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL wrap_grant got=%b exp=1000", req_ready); end
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL wrap_grant0 got=%b exp=0001", req_ready); end
        @(negedge clk); req_valid = 4'h0;
        @(negedge clk); #1;
        checks++; if ({resp_valid, resp_id, resp_sum, op_count} !== {1'b1, 2'd0, 16'h000F, 16'hFFFF}) begin failures++; $display("FAIL wrap_resp got valid=%b id=%0d sum=%h count=%h exp valid=1 id=0 sum=000f count=ffff", resp_valid, resp_id, resp_sum, op_count); end
        @(negedge clk); #1;
        checks++; if (op_count !== 16'h0000) begin failures++; $display("FAIL wrap_count got=%h exp=0000", op_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry();
        @(negedge clk);
        test_fairness();
        @(negedge clk); #1;
        test_backpressure();
        @(negedge clk); #1;
        test_withdraw();
        #1;
        test_reset_mid_op();
        @(negedge clk); #1;
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
